// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: state encoding and sizing helpers shared by the
// truth-table scanner top and its beat packer.
package tt_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_WAIT,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  function automatic int tt_beats(
    input int in_w,
    input int out_w
  );
    return (1 << in_w) / out_w;
  endfunction

  function automatic int tt_beat_w(
    input int in_w,
    input int out_w
  );
    int b;
    b = tt_beats(in_w, out_w);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

  function automatic int tt_cnt_w(
    input int settle
  );
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tt_beat_packer.sv
// tt_beat_packer: captured truth table plus beat streamer.
// Ports: clk, rst; wr_en/wr_addr/wr_bit write one table entry;
// load starts a stream at beat 0; m_valid/m_ready/m_data/m_last
// form the output stream; last_acc pulses as the final beat is taken.
module tt_beat_packer
  import tt_scan_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic             wr_bit,
  input  logic             load,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             last_acc
);

  localparam int DEPTH = 1 << IN_W;
  localparam int BEATS = tt_beats(IN_W, OUT_W);
  localparam int BW    = tt_beat_w(IN_W, OUT_W);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  logic [DEPTH-1:0] tbl;
  logic [BW-1:0]    beat;
  logic             valid;
  logic             at_last;
  logic [IN_W-1:0]  base;

  // Every scan rewrites every entry, so the table needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl[wr_addr] <= wr_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= '0;
    end else if (valid && m_ready) begin
      if (at_last) begin
        valid <= 1'b0;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

  // Table is frozen while streaming, so a direct read of the
  // current slice holds steady through any stall.
  assign at_last  = (beat == BEAT_LAST);
  assign base     = IN_W'(beat) * IN_W'(OUT_W);
  assign m_valid  = valid;
  assign m_data   = valid ? tbl[base +: OUT_W] : '0;
  assign m_last   = valid & at_last;
  assign last_acc = valid & m_ready & at_last;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps every IN_W-bit pattern on probe_o,
// captures sample_i per entry after SETTLE idle cycles, then streams
// the table LSB-first on m_valid/m_ready/m_data/m_last.
// Ports: clk, rst, start, busy, done, probe_o, sample_i, m_*.
// Option TT_SCAN_POPCOUNT_EN adds ones_cnt (count of 1 entries).
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int SETTLE = 2,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  probe_o,
  input  logic             sample_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last
`ifdef TT_SCAN_POPCOUNT_EN
  ,
  output logic [IN_W:0]    ones_cnt
`endif
);

  localparam int CW = tt_cnt_w(SETTLE);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IN_W-1:0] PROBE_LAST = '1;
  // With no settle time each entry is a single CAPTURE cycle.
  localparam state_t FIRST =
    (SETTLE == 0) ? CAPTURE : SETTLE_WAIT;

  state_t          state, nxt_state;
  logic [IN_W-1:0] nxt_probe;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            cap;
  logic            load;
  logic            clr;
  logic            last_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      probe_o <= '0;
      cnt     <= '0;
    end else begin
      state   <= nxt_state;
      probe_o <= nxt_probe;
      cnt     <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_probe = probe_o;
    nxt_cnt   = cnt;
    cap       = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_probe = '0;
          nxt_cnt   = '0;
          clr       = 1'b1;
          nxt_state = FIRST;
        end
      end
      SETTLE_WAIT: begin
        if (cnt == CNT_LAST) begin
          nxt_cnt   = '0;
          nxt_state = CAPTURE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        cap = 1'b1;
        if (probe_o == PROBE_LAST) begin
          load      = 1'b1;
          nxt_state = STREAM;
        end else begin
          nxt_probe = probe_o + IN_W'(1);
          nxt_state = FIRST;
        end
      end
      STREAM: begin
        if (last_acc) begin
          nxt_state = DONE;
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  assign busy = (state == SETTLE_WAIT) ||
                (state == CAPTURE) ||
                (state == STREAM);
  assign done = (state == DONE);

  tt_beat_packer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cap),
    .wr_addr  (probe_o),
    .wr_bit   (sample_i),
    .load     (load),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .last_acc (last_acc)
  );

`ifdef TT_SCAN_POPCOUNT_EN
  localparam logic [IN_W:0] ONE = {{IN_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ones_cnt <= '0;
    end else if (cap && sample_i) begin
      ones_cnt <= ones_cnt + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: vector table of scans checked through a
// beat scoreboard, plus start-spam and mid-run reset sequences.
module tb_truth_table_scanner;

  localparam int IN_W  = 10;
  localparam int OUT_W = 8;
  localparam int N     = 1 << IN_W;
  localparam int BEATS = N / OUT_W;
  localparam int LIM   = 9000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            start;
  logic [1:0]            busy;
  logic [1:0]            done;
  logic [1:0][IN_W-1:0]  probe;
  logic [1:0]            sample;
  logic [1:0]            m_valid;
  logic [1:0]            m_ready;
  logic [1:0][OUT_W-1:0] mdata;
  logic [1:0]            m_last;
`ifdef TT_SCAN_POPCOUNT_EN
  logic [1:0][IN_W:0]    ones;
`endif

  // u0: SETTLE=2 (defaults), u1: SETTLE=0
  truth_table_scanner #(.IN_W(IN_W), .SETTLE(2), .OUT_W(OUT_W)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]),
    .done(done[0]), .probe_o(probe[0]), .sample_i(sample[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(mdata[0]),
    .m_last(m_last[0])
`ifdef TT_SCAN_POPCOUNT_EN
    , .ones_cnt(ones[0])
`endif
  );

  truth_table_scanner #(.IN_W(IN_W), .SETTLE(0), .OUT_W(OUT_W)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]),
    .done(done[1]), .probe_o(probe[1]), .sample_i(sample[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(mdata[1]),
    .m_last(m_last[1])
`ifdef TT_SCAN_POPCOUNT_EN
    , .ones_cnt(ones[1])
`endif
  );

  // gate modes: 0 parity, 1 const 1, 2 const 0, 3 image,
  // 4 image through two registers
  int         gmode = 0;
  int         rmode = 0;
  int         sel = 0;
  logic [N-1:0] img;
  logic [1:0] r1, r2;

  function automatic logic gfn(input int m, input logic [IN_W-1:0] p);
    case (m)
      0:       return ^p;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return img[p];
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      r1[i] <= img[probe[i]];
      r2[i] <= r1[i];
    end
  end

  always_comb begin
    sample = '0;
    for (int i = 0; i < 2; i++)
      sample[i] = (gmode == 4) ? r2[i] : gfn(gmode, probe[i]);
  end

  initial begin
    m_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1 m_ready = (rmode != 0) ? 2'($urandom_range(0, 3)) : 2'b11;
    end
  end

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [OUT_W-1:0] m;
    logic             l;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad = 0;
  int dones = 0;
  int acc = 0;

  task automatic check(input string n, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, got, want);
    end
  endtask

  // expected beats; entries below 'shift' are unknown and masked
  task automatic push_exp(input int mode, input int shift);
    beat_t e;
    int src;
    int m;
    m = (mode == 4) ? 3 : mode;
    for (int b = 0; b < BEATS; b++) begin
      e = '0;
      for (int k = 0; k < OUT_W; k++) begin
        src = b * OUT_W + k - shift;
        if (src >= 0) begin
          e.m[k] = 1'b1;
          e.d[k] = gfn(m, IN_W'(src));
        end
      end
      e.l = (b == BEATS - 1);
      q.push_back(e);
    end
  endtask

  // scoreboard: every valid cycle must show the queue head
  always @(negedge clk) begin
    if (m_valid[sel]) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra got=%h want=none", mdata[sel]);
      end else begin
        if ((((mdata[sel] ^ q[0].d) & q[0].m) != '0) ||
            (m_last[sel] !== q[0].l)) begin
          bad++;
          $display("FAIL beat%0d got=%h/%b want=%h/%b mask=%h",
                   BEATS - q.size(), mdata[sel], m_last[sel],
                   q[0].d, q[0].l, q[0].m);
        end
        if (m_ready[sel]) begin
          void'(q.pop_front());
          acc++;
        end
      end
    end
    if (done[sel]) dones++;
  end

  task automatic pulse_start(input int s);
    @(posedge clk);
    #1 start[s] = 1'b1;
    @(posedge clk);
    #1 start[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input string n);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done[s] && c < LIM);
    check({n, "_done_seen"}, done[s], 1);
  endtask

  task automatic rst_check(input string n);
    check({n, "_busy"}, busy[sel], 0);
    check({n, "_done"}, done[sel], 0);
    check({n, "_probe"}, probe[sel], 0);
    check({n, "_valid"}, m_valid[sel], 0);
    check({n, "_data"}, mdata[sel], 0);
    check({n, "_last"}, m_last[sel], 0);
  endtask

  typedef struct {
    int s;
    int mode;
    int shift;
    int rnd;
    int ones;
  } vec_t;

  vec_t vt[6];

  task automatic run_scan(input vec_t v, input string n);
    int d0;
    sel   = v.s;
    gmode = v.mode;
    rmode = v.rnd;
    q.delete();
    push_exp(v.mode, v.shift);
    d0 = dones;
    pulse_start(v.s);
    @(negedge clk);
    check({n, "_busy"}, busy[v.s], 1);
    wait_done(v.s, n);
    check({n, "_busy_at_done"}, busy[v.s], 0);
    @(negedge clk);
    check({n, "_beats_left"}, q.size(), 0);
    check({n, "_dones"}, dones - d0, 1);
`ifdef TT_SCAN_POPCOUNT_EN
    if (v.ones >= 0) check({n, "_ones"}, ones[v.s], v.ones);
`endif
    rmode = 0;
  endtask

  initial begin
    int d0;
    int c;
    for (int i = 0; i < N; i += 32) img[i +: 32] = $urandom;
    vt[0] = '{0, 0, 0, 0, N / 2};
    vt[1] = '{1, 1, 0, 0, N};
    vt[2] = '{1, 2, 0, 0, 0};
    vt[3] = '{0, 3, 0, 1, $countones(img)};
    vt[4] = '{0, 4, 0, 0, $countones(img)};
    vt[5] = '{1, 4, 2, 0, -1};

    rst   = 1'b1;
    start = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_check("reset");
    rst = 1'b0;

    foreach (vt[i]) run_scan(vt[i], $sformatf("vec%0d", i));

    // start held high through a whole scan, then into DONE/IDLE
    sel = 0; gmode = 0; rmode = 0;
    q.delete();
    push_exp(0, 0);
    d0 = dones;
    @(posedge clk);
    #1 start[0] = 1'b1;
    wait_done(0, "spam1");
    check("spam_busy_at_done", busy[0], 0);
    check("spam_left1", q.size(), 0);
    push_exp(0, 0);
    @(negedge clk);
    check("spam_ignored_in_done", busy[0], 0);
    check("spam_one_done", dones - d0, 1);
    @(negedge clk);
    check("spam_restart_busy", busy[0], 1);
    check("spam_restart_probe", probe[0], 0);
    start[0] = 1'b0;
    wait_done(0, "spam2");
    @(negedge clk);
    check("spam_left2", q.size(), 0);
    check("spam_two_dones", dones - d0, 2);

    // reset during the scan at probe 300
    q.delete();
    push_exp(0, 0);
    d0 = dones;
    pulse_start(0);
    c = 0;
    while (probe[0] != 300 && c < LIM) begin
      @(negedge clk);
      c++;
    end
    check("rst_scan_reach", probe[0], 300);
    rst = 1'b1;
    @(negedge clk);
    rst_check("rst_scan");
    rst = 1'b0;

    // reset during the stream around beat 50
    q.delete();
    push_exp(0, 0);
    acc = 0;
    pulse_start(0);
    c = 0;
    while (acc < 50 && c < LIM) begin
      @(negedge clk);
      c++;
    end
    check("rst_stream_reach", acc >= 50, 1);
    rst = 1'b1;
    @(negedge clk);
    rst_check("rst_stream");
    rst = 1'b0;
    q.delete();
    repeat (4) @(negedge clk);
    check("rst_no_done", dones - d0, 0);
    check("rst_idle_busy", busy[0], 0);

    run_scan(vt[3], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
